array_ext_ctrl: RTL
===================

Name: array_ext_ctrl

Overview:
- Sequencing and arbitration controller placed in front of one single-port cache array macro (array_ext: 128 sets x 4 ways x 21 bits, RW0 port, per-way write mask, 1-cycle read latency).
- After reset it runs a zero-fill sweep over every set. It then shares the single RW0 port between one write requester and one read requester, with write priority.
- It also provides a one-entry response buffer so read data survives consumer backpressure.

Parameters:
- SETS, 128, number of sets (array depth)
- ADDR_W, 7, set address width (log2 SETS)
- WAYS, 4, ways per set (one mask bit per way)
- WAY_W, 21, bits per way
- DATA_W, 84, WAYS*WAY_W

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- w_valid  in  1  write request
- w_ready  out  1  write accepted this cycle when w_valid && w_ready
- w_addr  in  ADDR_W  write set
- w_data  in  DATA_W  write data; way i occupies [i*WAY_W +: WAY_W]
- w_mask  in  WAYS  per-way write enable
- r_valid  in  1  read request
- r_ready  out  1  read accepted this cycle when r_valid && r_ready
- r_addr  in  ADDR_W  read set
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer accepts read data
- resp_data  out  DATA_W  read data
- init_done  out  1  sweep complete; array usable
- RW0_addr  out  ADDR_W  to array
- RW0_en  out  1  to array
- RW0_wmode  out  1  to array; 1 = write
- RW0_wdata  out  DATA_W  to array
- RW0_wmask  out  WAYS  to array
- RW0_rdata  in  DATA_W  from array; valid the cycle after a read enable

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset). While reset is high: state=ST_INIT, init_cnt=0, rd_pend=0, hold_valid=0, hold_data=0, RW0_en forced 0. All ready/valid outputs and init_done are 0.
- ST_INIT, one write per cycle:
  - RW0_en=1, RW0_wmode=1, RW0_addr=init_cnt, RW0_wdata=0, RW0_wmask=all ones.
  - init_cnt increments each cycle.
  - After the write at init_cnt=SETS-1, next state is ST_RUN.
  - w_ready=r_ready=0 and init_done=0 throughout.
  - The sweep takes exactly SETS cycles. init_done=1 from the first ST_RUN cycle onward (registered).
- ST_RUN arbitration, evaluated each cycle:
  - w_ready=1.
  - wfire = w_valid.
  - r_ready = !w_valid && (!resp_valid || resp_ready).
  - rfire = r_valid && r_ready.
- RW0 drive in ST_RUN:
  - On wfire: en=1, wmode=1, addr=w_addr, wdata=w_data, wmask=w_mask.
  - Else on rfire: en=1, wmode=0, addr=r_addr, wmask=0, wdata=0.
  - Else: en=0, addr=0, wdata=0, wmask=0.
- Read pipeline:
  - rd_pend <= rfire.
  - In the cycle rd_pend=1: resp_valid=1 and resp_data=RW0_rdata (bypass). If resp_ready=0 in that cycle, RW0_rdata is captured into hold_data and hold_valid <= 1.
  - While hold_valid=1: resp_valid=1 and resp_data=hold_data. hold_valid clears on resp_ready.
  - When resp_valid=0, resp_data=hold_data (stable, not X).
- Throughput:
  - At most one read is outstanding or held.
  - With resp_ready tied high, back-to-back reads issue every cycle, one response per cycle, latency 1.
- Hazards:
  - A write to a set whose read is pending or held does not alter the delivered data. The response carries the pre-write value.
  - A simultaneous read and write to the same set issues the write first; the read follows and returns the new data.
- A read cannot starve a write. A read may starve under a continuous write stream; this is accepted.
- Reset asserted mid-sweep or with a response pending aborts everything: the sweep restarts at 0 and the response is dropped, with no output glitch beyond the reset values.

Decomposition:
- Package array_ctrl_pkg: SETS, ADDR_W, WAYS, WAY_W, DATA_W constants; state enum {ST_INIT, ST_RUN}.
- Sub-module array_ext_resp_buf: rd_pend/hold_valid/hold_data one-entry skid buffer producing resp_valid/resp_data and its "free" signal.
- Top module contains the FSM, the init counter, and the RW0 mux.

Test Plan:
- Release reset and monitor RW0 -> 128 consecutive writes: addr 0..127, wmask 4'hF, wdata 0. w_ready/r_ready low throughout. init_done rises on cycle 128.
- After init, read addr 7'h05 -> RW0_en=1, wmode=0 in the issue cycle. resp_valid=1 the next cycle with resp_data=0.
- Write addr 7'h12, data {4{21'h1ABCD}}, mask 4'b0101, then read 7'h12 -> ways 0 and 2 = 21'h1ABCD, ways 1 and 3 = 0.
- Assert w_valid and r_valid together (addr 7'h20 for both) -> write fires and r_ready=0. The read fires the next cycle and returns the written data.
- Read 7'h12 with resp_ready=0 for 5 cycles, and write 7'h12 to all-ones during the stall -> resp_valid held, resp_data = pre-write value, r_ready=0 throughout. The response is delivered when resp_ready=1.
- Assert reset at init_cnt=60, and separately with hold_valid=1 -> resp_valid=0 and init_done=0. The sweep restarts at addr 0 and completes 128 cycles after reset drops.

Source files
------------

// File: rtl/array_ctrl_pkg.sv
// Shared constants and FSM state type for the array_ext sequencing controller.
package array_ctrl_pkg;

  localparam int unsigned SETS   = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned WAYS   = 4;
  localparam int unsigned WAY_W  = 21;
  localparam int unsigned DATA_W = WAYS * WAY_W;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/array_ext_resp_buf.sv
// One-entry response skid buffer: passes array read data straight through in the
// cycle after a read, and parks it in a holding register if the consumer stalls.
module array_ext_resp_buf
  import array_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              rfire,
  input  logic [DATA_W-1:0] rdata,
  input  logic              resp_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              free
);

  logic              rd_pend_q;
  logic              hold_valid_q;
  logic [DATA_W-1:0] hold_data_q;

  // Read-pending flag and holding register; data is captured only on a stalled bypass cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      rd_pend_q <= rfire;
      if (rd_pend_q && !resp_ready) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= rdata;
      end else if (hold_valid_q && resp_ready) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  // rd_pend and hold_valid are never both set: a new read only issues once the slot drains.
  always_comb begin
    resp_valid = rd_pend_q || hold_valid_q;
    resp_data  = hold_data_q;
    if (rd_pend_q && !hold_valid_q) begin
      resp_data = rdata;
    end
    free = !resp_valid || resp_ready;
  end

endmodule

// File: rtl/array_ext_ctrl.sv
// Front-end controller for the single-port array_ext macro: zero-fills every set after
// reset, then arbitrates the RW0 port between one writer and one reader (writes win).
module array_ext_ctrl
  import array_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [WAYS-1:0]   w_mask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [WAYS-1:0]   RW0_wmask,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam logic [ADDR_W-1:0] LastSet = ADDR_W'(SETS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              wfire;
  logic              rfire;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic              buf_free;

  // State and sweep counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state, arbitration and RW0 mux; reset forces every handshake and the array enable low.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    wfire      = 1'b0;
    rfire      = 1'b0;
    init_done  = 1'b0;
    RW0_en     = 1'b0;
    RW0_wmode  = 1'b0;
    RW0_addr   = '0;
    RW0_wdata  = '0;
    RW0_wmask  = '0;

    unique case (state_q)
      ST_INIT: begin
        RW0_en     = 1'b1;
        RW0_wmode  = 1'b1;
        RW0_addr   = init_cnt_q;
        RW0_wmask  = '1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastSet) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        w_ready   = 1'b1;
        wfire     = w_valid;
        // A read only issues when the response slot will be free next cycle.
        r_ready   = !w_valid && buf_free;
        rfire     = r_valid && r_ready;
        if (wfire) begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_addr  = w_addr;
          RW0_wdata = w_data;
          RW0_wmask = w_mask;
        end else if (rfire) begin
          RW0_en   = 1'b1;
          RW0_addr = r_addr;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (reset) begin
      w_ready   = 1'b0;
      r_ready   = 1'b0;
      wfire     = 1'b0;
      rfire     = 1'b0;
      init_done = 1'b0;
      RW0_en    = 1'b0;
      RW0_wmode = 1'b0;
      RW0_addr  = '0;
      RW0_wdata = '0;
      RW0_wmask = '0;
    end
  end

  array_ext_resp_buf u_resp_buf (
    .clock      (clock),
    .reset      (reset),
    .rfire      (rfire),
    .rdata      (RW0_rdata),
    .resp_ready (resp_ready),
    .resp_valid (buf_valid),
    .resp_data  (buf_data),
    .free       (buf_free)
  );

  // Hide any in-flight response while reset is held.
  always_comb begin
    resp_valid = buf_valid && !reset;
    resp_data  = reset ? '0 : buf_data;
  end

endmodule
